imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_if.sv | 43 ++++
 rtl/imem_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/imem_arbiter_if.sv
// Fetch-port, loader-port and memory-side signals shared by imem_arbiter and its requesters.
// Handshake: a requester raises req with addr/we/wdata stable and holds them until it samples
// gnt=1 on a rising clk edge; dropping req before that withdraws the request with no effect.
// A granted read, or any access to an illegal address, is answered by a one-cycle rvalid
// pulse in the following cycle. err and rdata are zero whenever rvalid is low.
interface imem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             f_req;
  logic [31:0]      f_addr;
  logic             f_gnt;
  logic             f_rvalid;
  logic [WIDTH-1:0] f_rdata;
  logic             f_err;

  logic             l_req;
  logic             l_we;
  logic [31:0]      l_addr;
  logic [WIDTH-1:0] l_wdata;
  logic             l_gnt;
  logic             l_rvalid;
  logic [WIDTH-1:0] l_rdata;
  logic             l_err;

  logic [31:0]      m_addr;
  logic             m_we;
  logic [WIDTH-1:0] m_wdata;
  logic [WIDTH-1:0] m_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output m_addr, m_we, m_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  m_addr, m_we, m_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Arbitrates one shared instruction memory between a boot loader and the fetch unit.
// Loader-only until boot_done, then loader priority with a bounded fetch starvation window.
module imem_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_done,
  imem_arbiter_if.slave bus,
  output logic          state
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int              SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [29:0]     ADDR_LIM   = 30'(DEPTH);

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          f_rvalid_q, f_rvalid_d;
  logic          l_rvalid_q, l_rvalid_d;
  logic          rsp_err_q, rsp_err_d;

  logic             f_bad, l_bad;
  logic             f_gnt, l_gnt;
  logic [31:0]      m_addr_c;
  logic             m_we_c;
  logic [WIDTH-1:0] m_wdata_c;

  assign f_bad = (bus.f_addr[1:0] != 2'b00) || (bus.f_addr[31:2] >= ADDR_LIM);
  assign l_bad = (bus.l_addr[1:0] != 2'b00) || (bus.l_addr[31:2] >= ADDR_LIM);

  // Grants are gated by rst so nothing reaches memory while reset is asserted.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst) begin
      if (state_q == ST_RUN && bus.f_req && (!bus.l_req || starve_q == STARVE_LIM)) begin
        f_gnt = 1'b1;
      end else if (bus.l_req) begin
        l_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    m_addr_c  = '0;
    m_we_c    = 1'b0;
    m_wdata_c = '0;
    if (f_gnt && !f_bad) begin
      m_addr_c = bus.f_addr;
    end else if (l_gnt && !l_bad) begin
      m_addr_c  = bus.l_addr;
      m_we_c    = bus.l_we;
      m_wdata_c = bus.l_we ? bus.l_wdata : '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    f_rvalid_d = f_gnt;
    l_rvalid_d = l_gnt && (!bus.l_we || l_bad);
    rsp_err_d  = (f_gnt && f_bad) || (l_gnt && l_bad);
    if (state_q == ST_BOOT && boot_done) begin
      state_d = ST_RUN;
    end
    // Counts consecutive loader wins while a fetch is waiting.
    if (f_gnt || !bus.f_req) begin
      starve_d = '0;
    end else if (l_gnt && starve_q != STARVE_LIM) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      starve_q   <= '0;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      f_rvalid_q <= f_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.f_gnt    = f_gnt;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.f_err    = f_rvalid_q & rsp_err_q;
  assign bus.f_rdata  = (f_rvalid_q && !rsp_err_q) ? bus.m_rdata : '0;

  assign bus.l_gnt    = l_gnt;
  assign bus.l_rvalid = l_rvalid_q;
  assign bus.l_err    = l_rvalid_q & rsp_err_q;
  assign bus.l_rdata  = (l_rvalid_q && !rsp_err_q) ? bus.m_rdata : '0;

  assign bus.m_addr   = m_addr_c;
  assign bus.m_we     = m_we_c;
  assign bus.m_wdata  = m_wdata_c;

  assign state = state_q;

endmodule
